// File: rtl/d_sram2axi_if.sv
// Bundle of the cache-side SRAM-like port and the single-beat AXI4 master port of d_sram2axi.
// Modport master is the bridge's view; modport slave is the cache plus AXI fabric around it.
interface d_sram2axi_if #(
  parameter int ID_WIDTH = 4
);
  // SRAM-like side
  logic                data_req;
  logic                data_wr;
  logic [1:0]          data_size;
  logic [31:0]         data_addr;
  logic [31:0]         data_wdata;
  logic [31:0]         data_rdata;
  logic                data_addr_ok;
  logic                data_data_ok;

  // AXI read address / data
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  // AXI write address / data / response
  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/d_sram2axi.sv
// Data-cache SRAM-like to single-beat AXI4 bridge, one transaction outstanding.
// Optional sticky bus_err output on SLVERR/DECERR responses: define D_SRAM2AXI_ERR_RESP_EN.
module d_sram2axi #(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID   = ID_WIDTH'(1)
) (
  input  logic          clk,
  input  logic          resetn,
  d_sram2axi_if.master  bus
`ifdef D_SRAM2AXI_ERR_RESP_EN
  ,
  output logic          bus_err
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        addr_ok, data_ok;
  logic [3:0]  wstrb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Direction is carried by the state itself, so no separate wr flag is kept.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;

    case (state_q)
      IDLE: begin
        // Gated by resetn so nothing is acknowledged while reset is held.
        addr_ok = bus.data_req & resetn;
        if (bus.data_req) begin
          addr_d    = bus.data_addr;
          size_d    = (bus.data_size == 2'd3) ? 2'd2 : bus.data_size;
          wdata_d   = bus.data_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.data_wr ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (bus.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (bus.rvalid) begin
          rdata_d = bus.rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W channels complete independently, in any order.
        awvalid   = ~aw_done_q;
        wvalid    = ~w_done_q;
        aw_done_d = aw_done_q | (awvalid & bus.awready);
        w_done_d  = w_done_q | (wvalid & bus.wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bus.bvalid) state_d = DONE;
      end
      DONE: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign bus.data_rdata   = rdata_q;
  assign bus.data_addr_ok = addr_ok;
  assign bus.data_data_ok = data_ok;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arvalid = arvalid;
  assign bus.rready  = rready;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;
  assign bus.awvalid = awvalid;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = wvalid;
  assign bus.bready  = bready;

`ifdef D_SRAM2AXI_ERR_RESP_EN
  logic bus_err_q, bus_err_d;

  always_comb begin
    bus_err_d = bus_err_q
              | (bus.rvalid & rready & bus.rresp[1])
              | (bus.bvalid & bready & bus.bresp[1]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) bus_err_q <= 1'b0;
    else         bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

  // IDs and rlast are not inspected; responses only matter with the error option.
  logic unused_inputs;
  assign unused_inputs = ^{bus.rid, bus.rlast, bus.bid, bus.rresp, bus.bresp};

endmodule

// File: tb/tb_d_sram2axi.sv
// Scoreboard bench for d_sram2axi: stimulus tasks push expected completions, a monitor pops them on data_ok.
// Build with D_SRAM2AXI_ERR_RESP_EN defined to also exercise the bus_err output.
module tb_d_sram2axi;

  logic clk;
  logic resetn;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          start;
  } sb_t;

  sb_t sb_q[$];

  d_sram2axi_if #(.ID_WIDTH(4)) sif ();

`ifdef D_SRAM2AXI_ERR_RESP_EN
  logic bus_err;
  d_sram2axi #(.ID_WIDTH(4), .AXI_ID(4'd1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (sif.master),
    .bus_err(bus_err)
  );
`else
  d_sram2axi #(.ID_WIDTH(4), .AXI_ID(4'd1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (sif.master)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Completion monitor: every data_ok must match the oldest outstanding request.
  always @(negedge clk) begin
    sb_t e;
    #2;
    if (sif.data_data_ok) begin
      if (sb_q.size() == 0) begin
        check("spurious_data_ok", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("data_rdata", sif.data_rdata, e.rdata);
        check("latency", 32'(cyc - e.start), 32'(e.lat));
        $display("txn done: rdata=0x%08h latency=%0d", sif.data_rdata, cyc - e.start);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic do_read(input logic [31:0] addr, input logic [1:0] size, input logic [2:0] exp_size,
                         input logic [31:0] rdata, input int ar_wait, input int r_wait);
    sb_t e;
    @(negedge clk);
    sif.data_req  = 1'b1;
    sif.data_wr   = 1'b0;
    sif.data_size = size;
    sif.data_addr = addr;
    #1 check("rd_addr_ok", 32'(sif.data_addr_ok), 32'd1);
    e.rdata = rdata;
    e.lat   = 3 + ar_wait + r_wait;
    e.start = cyc;
    sb_q.push_back(e);
    last_rd = rdata;
    @(negedge clk);
    // Request pins wander while the transaction runs; the latched copy must drive AXI.
    sif.data_addr = 32'hFFFF_0000;
    sif.data_size = 2'd1;
    for (int i = 0; i <= ar_wait; i++) begin
      sif.arready = (i == ar_wait);
      #1;
      check("arvalid", 32'(sif.arvalid), 32'd1);
      check("araddr", sif.araddr, addr);
      check("arsize", 32'(sif.arsize), 32'(exp_size));
      check("rd_busy_addr_ok", 32'(sif.data_addr_ok), 32'd0);
      @(negedge clk);
    end
    sif.arready = 1'b0;
    for (int j = 0; j <= r_wait; j++) begin
      sif.rvalid = (j == r_wait);
      sif.rdata  = (j == r_wait) ? rdata : 32'h0BAD_0BAD;
      #1;
      check("rready", 32'(sif.rready), 32'd1);
      check("rd_arvalid_low", 32'(sif.arvalid), 32'd0);
      @(negedge clk);
    end
    sif.rvalid   = 1'b0;
    sif.data_req = 1'b0;
    @(negedge clk);
    $display("read  addr=0x%08h size=%0d ar_wait=%0d r_wait=%0d", addr, size, ar_wait, r_wait);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [1:0] size, input logic [2:0] exp_size,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int aw_wait, input int w_wait, input int b_wait, input logic [1:0] bresp);
    sb_t e;
    int  n;
    @(negedge clk);
    sif.data_req   = 1'b1;
    sif.data_wr    = 1'b1;
    sif.data_size  = size;
    sif.data_addr  = addr;
    sif.data_wdata = wdata;
    #1 check("wr_addr_ok", 32'(sif.data_addr_ok), 32'd1);
    n = (aw_wait > w_wait) ? aw_wait : w_wait;
    e.rdata = last_rd;
    e.lat   = 3 + n + b_wait;
    e.start = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    // data_req drops mid-transaction; the write must still complete.
    sif.data_req   = 1'b0;
    sif.data_addr  = 32'hFFFF_0000;
    sif.data_wdata = 32'h5555_5555;
    sif.data_size  = 2'd2;
    for (int i = 0; i <= n; i++) begin
      sif.awready = (i == aw_wait);
      sif.wready  = (i == w_wait);
      #1;
      check("awvalid", 32'(sif.awvalid), 32'(i <= aw_wait));
      check("wvalid", 32'(sif.wvalid), 32'(i <= w_wait));
      if (i == aw_wait) begin
        check("awaddr", sif.awaddr, addr);
        check("awsize", 32'(sif.awsize), 32'(exp_size));
        check("awlen", 32'(sif.awlen), 32'd0);
        check("awburst", 32'(sif.awburst), 32'd1);
        check("awid", 32'(sif.awid), 32'd1);
      end
      if (i == w_wait) begin
        check("wdata", sif.wdata, wdata);
        check("wstrb", 32'(sif.wstrb), 32'(strb));
        check("wlast", 32'(sif.wlast), 32'd1);
      end
      @(negedge clk);
    end
    sif.awready = 1'b0;
    sif.wready  = 1'b0;
    for (int j = 0; j <= b_wait; j++) begin
      sif.bvalid = (j == b_wait);
      sif.bresp  = (j == b_wait) ? bresp : 2'b00;
      #1;
      check("bready", 32'(sif.bready), 32'd1);
      check("resp_aw_w_low", 32'({sif.awvalid, sif.wvalid}), 32'd0);
      @(negedge clk);
    end
    sif.bvalid = 1'b0;
    sif.bresp  = 2'b00;
    @(negedge clk);
    $display("write addr=0x%08h size=%0d aw_wait=%0d w_wait=%0d b_wait=%0d", addr, size, aw_wait, w_wait, b_wait);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valids"}, 32'({sif.arvalid, sif.rready, sif.awvalid, sif.wvalid, sif.bready}), 32'd0);
    check({tag, "_addr_ok"}, 32'(sif.data_addr_ok), 32'd0);
    check({tag, "_data_ok"}, 32'(sif.data_data_ok), 32'd0);
  endtask

  initial begin
    resetn         = 1'b0;
    sif.data_req   = 1'b1;
    sif.data_wr    = 1'b0;
    sif.data_size  = 2'd0;
    sif.data_addr  = 32'h0;
    sif.data_wdata = 32'h0;
    sif.arready    = 1'b0;
    sif.rid        = 4'd1;
    sif.rdata      = 32'h0;
    sif.rresp      = 2'b00;
    sif.rlast      = 1'b1;
    sif.rvalid     = 1'b0;
    sif.awready    = 1'b0;
    sif.wready     = 1'b0;
    sif.bid        = 4'd1;
    sif.bresp      = 2'b00;
    sif.bvalid     = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_rdata", sif.data_rdata, 32'h0);
    check("arlen", 32'(sif.arlen), 32'd0);
    check("arburst", 32'(sif.arburst), 32'd1);
    check("arid", 32'(sif.arid), 32'd1);
    check("wlast_const", 32'(sif.wlast), 32'd1);
`ifdef D_SRAM2AXI_ERR_RESP_EN
    check("reset_bus_err", 32'(bus_err), 32'd0);
`endif
    @(negedge clk);
    sif.data_req = 1'b0;
    resetn       = 1'b1;
    @(negedge clk);

    do_read (32'h1000_0010, 2'd2, 3'd2, 32'hDEAD_BEEF, 0, 0);
    do_write(32'h2000_0003, 2'd0, 3'd0, 32'h0000_00AB, 4'b1000, 0, 0, 0, 2'b00);
    do_write(32'h2000_0102, 2'd1, 3'd1, 32'h1234_0000, 4'b1100, 3, 0, 1, 2'b00);
    do_read (32'h1234_5670, 2'd2, 3'd2, 32'hCAFE_F00D, 5, 2);
    do_write(32'h0000_0040, 2'd3, 3'd2, 32'hA5A5_5A5A, 4'b1111, 0, 2, 0, 2'b00);
    do_write(32'h0000_0081, 2'd0, 3'd0, 32'h0000_CD00, 4'b0010, 2, 2, 2, 2'b00);
    do_write(32'h0000_0100, 2'd1, 3'd1, 32'h0000_BEEF, 4'b0011, 1, 0, 0, 2'b00);
    do_read (32'h0000_0201, 2'd3, 3'd2, 32'h0102_0304, 1, 0);

    // Reset asserted while the bridge waits in RD_DATA: aborts without data_ok.
    @(negedge clk);
    sif.data_req  = 1'b1;
    sif.data_wr   = 1'b0;
    sif.data_size = 2'd2;
    sif.data_addr = 32'h3000_0000;
    #1 check("rst_addr_ok", 32'(sif.data_addr_ok), 32'd1);
    @(negedge clk);
    sif.data_req = 1'b0;
    sif.arready  = 1'b1;
    #1 check("rst_arvalid", 32'(sif.arvalid), 32'd1);
    @(negedge clk);
    sif.arready = 1'b0;
    #1 check("rst_rready", 32'(sif.rready), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check_quiet("async_rst");
    check("async_rst_rdata", sif.data_rdata, 32'h0);
    last_rd = 32'h0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_quiet("post_rst");
    do_read (32'h3000_0004, 2'd2, 3'd2, 32'h7777_8888, 0, 0);

`ifdef D_SRAM2AXI_ERR_RESP_EN
    check("clean_bus_err", 32'(bus_err), 32'd0);
    do_write(32'h4000_0000, 2'd2, 3'd2, 32'h1111_2222, 4'b1111, 0, 0, 0, 2'b10);
    #1 check("bus_err_set", 32'(bus_err), 32'd1);
    do_read (32'h4000_0010, 2'd2, 3'd2, 32'h3333_4444, 0, 0);
    #1 check("bus_err_sticky", 32'(bus_err), 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
